// File: rtl/layer_argmax_pkg.sv
// Shared types and Q-format constants for the final-layer argmax classifier.
package layer_argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int                        SCORE_W   = 16;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = 16'sh8000;
  localparam logic signed [SCORE_W-1:0] SCORE_SAT = 16'sh7FFF;

  // Winner minus runner-up, evaluated at 17 bits so the full range is representable.
  function automatic logic [SCORE_W-1:0] sat_margin(input logic signed [SCORE_W-1:0] hi,
                                                    input logic signed [SCORE_W-1:0] lo);
    logic signed [SCORE_W:0] diff;
    diff = {hi[SCORE_W-1], hi} - {lo[SCORE_W-1], lo};
    if (diff > 17'sh07FFF) begin
      return SCORE_SAT;
    end else begin
      return diff[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/argmax_step.sv
// One scan step: folds a candidate into the running (best, best_idx[, second]) state.
// Runner-up tracking exists only when ARGMAX_MARGIN_EN is defined.
module argmax_step
  import layer_argmax_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                      first,
  input  logic signed [SCORE_W-1:0] cand,
  input  logic        [IDX_W-1:0]   cand_idx,
  input  logic signed [SCORE_W-1:0] best,
  input  logic        [IDX_W-1:0]   best_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [SCORE_W-1:0] second,
  output logic signed [SCORE_W-1:0] next_second,
`endif
  output logic signed [SCORE_W-1:0] next_best,
  output logic        [IDX_W-1:0]   next_idx
);

  // Compare/update; a tie never displaces the lower-index winner.
  always_comb begin
    next_best = best;
    next_idx  = best_idx;
`ifdef ARGMAX_MARGIN_EN
    next_second = second;
`endif
    if (first) begin
      next_best = cand;
      next_idx  = cand_idx;
`ifdef ARGMAX_MARGIN_EN
      next_second = SCORE_MIN;
`endif
    end else if (cand > best) begin
      next_best = cand;
      next_idx  = cand_idx;
`ifdef ARGMAX_MARGIN_EN
      next_second = best;
`endif
    end else begin
`ifdef ARGMAX_MARGIN_EN
      if (cand > second) begin
        next_second = cand;
      end else begin
        next_second = second;
      end
`else
      next_best = best;
`endif
    end
  end

endmodule

// File: rtl/layer_argmax_classifier.sv
// Snapshots the final layer's node outputs after its fixed latency, scans them for the
// winning class and offers the result on valid/ready. ARGMAX_MARGIN_EN adds class_margin.
module layer_argmax_classifier
  import layer_argmax_pkg::*;
#(
  parameter int NUM_CLASSES   = 5,
  parameter int LAYER_LATENCY = 3,
  parameter int IDX_W         = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [SCORE_W*NUM_CLASSES-1:0] n_flat,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               class_idx,
  output logic [SCORE_W-1:0]             class_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W-1:0]             class_margin
`endif
);

  localparam logic [3:0]       CNT_LOAD = 4'(LAYER_LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                    state_r;
  logic        [3:0]         cnt_r;
  logic signed [SCORE_W-1:0] snap_r [NUM_CLASSES];
  logic        [IDX_W-1:0]   scan_idx_r;
  logic signed [SCORE_W-1:0] best_r;
  logic        [IDX_W-1:0]   best_idx_r;
  logic signed [SCORE_W-1:0] cand_s;
  logic signed [SCORE_W-1:0] next_best_s;
  logic        [IDX_W-1:0]   next_idx_s;
  logic                      first_s;
`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] second_r;
  logic signed [SCORE_W-1:0] next_second_s;
`endif

  assign first_s = (scan_idx_r == {IDX_W{1'b0}});

  // Select the snapshot entry addressed by the scan index.
  always_comb begin
    cand_s = SCORE_MIN;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      cand_s = (scan_idx_r == IDX_W'(k)) ? snap_r[k] : cand_s;
    end
  end

  argmax_step #(
    .IDX_W(IDX_W)
  ) u_step (
    .first      (first_s),
    .cand       (cand_s),
    .cand_idx   (scan_idx_r),
    .best       (best_r),
    .best_idx   (best_idx_r),
`ifdef ARGMAX_MARGIN_EN
    .second     (second_r),
    .next_second(next_second_s),
`endif
    .next_best  (next_best_s),
    .next_idx   (next_idx_s)
  );

  // Control FSM, snapshot capture, scan registers and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      scan_idx_r  <= {IDX_W{1'b0}};
      best_r      <= 16'sh0000;
      best_idx_r  <= {IDX_W{1'b0}};
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      class_idx   <= {IDX_W{1'b0}};
      class_score <= 16'h0000;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        snap_r[k] <= 16'sh0000;
      end
`ifdef ARGMAX_MARGIN_EN
      second_r     <= 16'sh0000;
      class_margin <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r   <= CNT_LOAD;
            busy    <= 1'b1;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              snap_r[k] <= n_flat[k*SCORE_W +: SCORE_W];
            end
            scan_idx_r <= {IDX_W{1'b0}};
            state_r    <= SCAN;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        SCAN: begin
          best_r     <= next_best_s;
          best_idx_r <= next_idx_s;
`ifdef ARGMAX_MARGIN_EN
          second_r   <= next_second_s;
`endif
          if (scan_idx_r == LAST_IDX) begin
            class_idx   <= next_idx_s;
            class_score <= next_best_s;
`ifdef ARGMAX_MARGIN_EN
            class_margin <= sat_margin(next_best_s, next_second_s);
`endif
            out_valid   <= 1'b1;
            state_r     <= HOLD;
          end else begin
            scan_idx_r <= scan_idx_r + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // A start in the accepting cycle chains straight into the next run.
            if (start) begin
              cnt_r   <= CNT_LOAD;
              state_r <= WAIT;
            end else begin
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_argmax_classifier.sv
// Scoreboard bench for layer_argmax_classifier at default parameters.
module tb_layer_argmax_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] n_flat;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  class_idx;
  logic [15:0] class_score;
`ifdef ARGMAX_MARGIN_EN
  logic [15:0] class_margin;
`endif

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] score;
    logic [15:0] margin;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  layer_argmax_classifier #(
    .NUM_CLASSES(5),
    .LAYER_LATENCY(3),
    .IDX_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_flat      (n_flat),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .class_score (class_score)
`ifdef ARGMAX_MARGIN_EN
    ,
    .class_margin(class_margin)
`endif
  );

  function automatic logic [79:0] pack(input int a, input int b, input int c, input int d, input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Reference: first maximum wins, runner-up is the max of every other entry.
  function automatic exp_t model(input logic [79:0] v);
    int   val[5];
    int   w;
    int   s;
    exp_t e;
    for (int k = 0; k < 5; k++) val[k] = int'($signed(v[16*k +: 16]));
    w = 0;
    for (int k = 1; k < 5; k++) if (val[k] > val[w]) w = k;
    s = -40000;
    for (int k = 0; k < 5; k++) if (k != w && val[k] > s) s = val[k];
    e.idx    = 4'(w);
    e.score  = 16'(val[w]);
    e.margin = (val[w] - s > 32767) ? 16'h7FFF : 16'(val[w] - s);
    return e;
  endfunction

  function automatic logic [79:0] rand_vec();
    logic [79:0] v;
    for (int k = 0; k < 5; k++) begin
      case ($urandom_range(0, 3))
        0:       v[16*k +: 16] = 16'h8000;
        1:       v[16*k +: 16] = 16'h7FFF;
        2:       v[16*k +: 16] = 16'h0064;
        default: v[16*k +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; n_flat = 80'h0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
    end
    checks++;
    if (class_idx !== 4'd0 || class_score !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: idx=%0d score=%h, expected 0 0000", class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    checks++;
    if (class_margin !== 16'h0000) begin
      failures++;
      $display("FAIL reset_margin: got %h expected 0000", class_margin);
    end
`endif
  endtask

  task automatic test_tie_timing();
    exp_t        e;
    int          c;
    logic [79:0] v;
    v = pack(10, 200, 50, 200, 7);
    n_flat = v; out_ready = 1'b1; start = 1'b1;
    sbq.push_back(model(v));
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL tie_busy_rise: busy=%b expected 1", busy);
    end
    c = 1;
    while (!out_valid && c < 30) begin tick(); c++; end
    checks++;
    if (c !== 9) begin
      failures++;
      $display("FAIL tie_latency: out_valid in cycle %0d, expected 9", c);
    end
    e = sbq.pop_front();
    checks++;
    if (class_idx !== e.idx || class_score !== e.score) begin
      failures++;
      $display("FAIL tie_result: idx=%0d score=%h, expected idx=%0d score=%h", class_idx, class_score, e.idx, e.score);
    end
`ifdef ARGMAX_MARGIN_EN
    checks++;
    if (class_margin !== e.margin) begin
      failures++;
      $display("FAIL tie_margin: got %h expected %h", class_margin, e.margin);
    end
`endif
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tie_one_cycle: out_valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_value_table();
    logic [79:0] tbl[5];
    exp_t        e;
    int          c;
    tbl[0] = pack(-5, -3, -9, -100, -4);
    tbl[1] = pack(32767, -32768, 0, 0, 0);
    tbl[2] = pack(32767, -32768, -32768, -32768, -32768);
    tbl[3] = pack(-32768, -32768, -32768, -32768, -32768);
    tbl[4] = pack(1, 2, 3, 4, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_flat = tbl[i]; start = 1'b1;
      sbq.push_back(model(tbl[i]));
      tick();
      start = 1'b0;
      c = 1;
      while (!out_valid && c < 30) begin tick(); c++; end
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || class_idx !== e.idx || class_score !== e.score) begin
        failures++;
        $display("FAIL table%0d_result: valid=%b idx=%0d score=%h, expected 1 idx=%0d score=%h", i, out_valid, class_idx, class_score, e.idx, e.score);
      end
`ifdef ARGMAX_MARGIN_EN
      checks++;
      if (class_margin !== e.margin) begin
        failures++;
        $display("FAIL table%0d_margin: got %h expected %h", i, class_margin, e.margin);
      end
`endif
      tick();
    end
  endtask

  task automatic test_capture_window();
    logic [79:0] f[14];
    exp_t        e;
    int          c;
    // Each cycle puts the winner on a different class, so any capture skew is visible.
    for (int i = 0; i < 14; i++) begin
      f[i] = pack(i*10, i*10+1, i*10+2, i*10+3, i*10+4);
      f[i][16*(i%5) +: 16] = 16'(1000 + i);
    end
    out_ready = 1'b1;
    sbq.push_back(model(f[3]));
    n_flat = f[0]; start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (!out_valid && c < 13) begin n_flat = f[c]; tick(); c++; end
    e = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1 || class_idx !== e.idx || class_score !== e.score) begin
      failures++;
      $display("FAIL capture_result: valid=%b idx=%0d score=%h, expected 1 idx=%0d score=%h", out_valid, class_idx, class_score, e.idx, e.score);
    end
`ifdef ARGMAX_MARGIN_EN
    checks++;
    if (class_margin !== e.margin) begin
      failures++;
      $display("FAIL capture_margin: got %h expected %h", class_margin, e.margin);
    end
`endif
    tick();
  endtask

  task automatic test_stall();
    logic [79:0] v;
    exp_t        e;
    int          c;
    int          bad;
    v = pack(-7, 12, 12, -1, 3);
    out_ready = 1'b0; n_flat = v; start = 1'b1;
    sbq.push_back(model(v));
    tick();
    start = 1'b0;
    c = 1;
    while (!out_valid && c < 30) begin tick(); c++; end
    e = sbq[0];
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      n_flat = rand_vec();
      start = (i == 5);
      tick();
      if (out_valid !== 1'b1 || busy !== 1'b1 || class_idx !== e.idx || class_score !== e.score) bad++;
`ifdef ARGMAX_MARGIN_EN
      if (class_margin !== e.margin) bad++;
`endif
    end
    start = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_stable: %0d unstable samples, expected 0 (idx=%0d score=%h)", bad, e.idx, e.score);
    end
    void'(sbq.pop_front());
    v = pack(-1, -2, 300, 299, -300);
    n_flat = v; out_ready = 1'b1; start = 1'b1;
    sbq.push_back(model(v));
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_handshake: busy=%b out_valid=%b, expected 1 0", busy, out_valid);
    end
    c = 1;
    while (!out_valid && c < 30) begin tick(); c++; end
    checks++;
    if (c !== 9) begin
      failures++;
      $display("FAIL b2b_latency: out_valid in cycle %0d, expected 9", c);
    end
    e = sbq.pop_front();
    checks++;
    if (class_idx !== e.idx || class_score !== e.score) begin
      failures++;
      $display("FAIL b2b_result: idx=%0d score=%h, expected idx=%0d score=%h", class_idx, class_score, e.idx, e.score);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_ignored_start: %0d cycles busy/valid after drain, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [79:0] v;
    exp_t        e;
    int          c;
    v = pack(4, 9, -2, 9, 1);
    out_ready = 1'b1; n_flat = v; start = 1'b1;
    sbq.push_back(model(v));
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || class_idx !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: busy=%b out_valid=%b idx=%0d, expected 0 0 0", busy, out_valid, class_idx);
    end
    void'(sbq.pop_front());
    tick();
    reset = 1'b0;
    tick();
    v = pack(-50, -60, -40, -45, -41);
    n_flat = v; start = 1'b1;
    sbq.push_back(model(v));
    tick();
    start = 1'b0;
    c = 1;
    while (!out_valid && c < 30) begin tick(); c++; end
    e = sbq.pop_front();
    checks++;
    if (c !== 9 || class_idx !== e.idx || class_score !== e.score) begin
      failures++;
      $display("FAIL post_reset_result: cycle=%0d idx=%0d score=%h, expected 9 idx=%0d score=%h", c, class_idx, class_score, e.idx, e.score);
    end
`ifdef ARGMAX_MARGIN_EN
    checks++;
    if (class_margin !== e.margin) begin
      failures++;
      $display("FAIL post_reset_margin: got %h expected %h", class_margin, e.margin);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    logic [79:0] v;
    exp_t        e;
    int          c;
    out_ready = 1'b1;
    v = rand_vec(); n_flat = v; start = 1'b1;
    sbq.push_back(model(v));
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c = 1;
      while (!out_valid && c < 30) begin tick(); c++; end
      e = sbq.pop_front();
      checks++;
      if (c !== 9 || class_idx !== e.idx || class_score !== e.score) begin
        failures++;
        $display("FAIL b2b%0d_result: cycle=%0d idx=%0d score=%h, expected 9 idx=%0d score=%h", i, c, class_idx, class_score, e.idx, e.score);
      end
`ifdef ARGMAX_MARGIN_EN
      checks++;
      if (class_margin !== e.margin) begin
        failures++;
        $display("FAIL b2b%0d_margin: got %h expected %h", i, class_margin, e.margin);
      end
`endif
      if (i < 5) begin
        v = rand_vec(); n_flat = v; start = 1'b1;
        sbq.push_back(model(v));
      end
      tick();
      start = 1'b0;
      checks++;
      if (busy !== (i < 5)) begin
        failures++;
        $display("FAIL b2b%0d_busy: busy=%b expected %b", i, busy, (i < 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie_timing();
    test_value_table();
    test_capture_window();
    test_stall();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
